// File: rtl/rv_iommu_wsi_gen.sv
// Wired-signalled interrupt generator for the RISC-V IOMMU: latches pending
// events per source and drives level or fixed-width pulse wires per vector.
module rv_iommu_wsi_gen #(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned N_INT_VEC    = 16,
  parameter int unsigned PULSE_CYCLES = 4,
  localparam int unsigned VEC_W = (N_INT_VEC > 1) ? $clog2(N_INT_VEC) : 1,
  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wsi_en_i,
  input  logic                   mode_pulse_i,
  input  logic [N_SRC*VEC_W-1:0] ivec_i,
  input  logic [N_SRC-1:0]       ie_i,
  input  logic [N_SRC-1:0]       ip_set_i,
  input  logic [N_SRC-1:0]       ip_clr_i,
  output logic [N_SRC-1:0]       ip_o,
  output logic [N_INT_VEC-1:0]   wsi_wires_o
);

  localparam logic [VEC_W:0]   VEC_LIM = (VEC_W + 1)'(N_INT_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_SRC-1:0]                ip_d, ip_q;
  logic [N_SRC-1:0]                prev_d, prev_q;
  logic [N_SRC-1:0]                act, rise;
  logic [N_INT_VEC-1:0]            lvl_d, lvl_q;
  logic [N_INT_VEC-1:0]            wires_d, wires_q;
  logic [N_INT_VEC-1:0]            lvl_hit, rise_hit;
  logic [N_INT_VEC-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic                            mode_q;
  logic                            flush;

  // Set wins over clear so a new event is never lost; ivec range check is one bit wider.
  always_comb begin
    ip_d = (ip_q & ~ip_clr_i) | ip_set_i;
    for (int s = 0; s < int'(N_SRC); s++) begin
      act[s] = ip_q[s] & ie_i[s] & ({1'b0, ivec_i[s*VEC_W +: VEC_W]} < VEC_LIM);
    end
    rise = act & ~prev_q;
  end

  always_comb begin
    lvl_hit  = '0;
    rise_hit = '0;
    for (int v = 0; v < int'(N_INT_VEC); v++) begin
      for (int s = 0; s < int'(N_SRC); s++) begin
        lvl_hit[v]  = lvl_hit[v]  | (act[s]  & (ivec_i[s*VEC_W +: VEC_W] == VEC_W'(v)));
        rise_hit[v] = rise_hit[v] | (rise[s] & (ivec_i[s*VEC_W +: VEC_W] == VEC_W'(v)));
      end
    end
  end

  // Disable or a mode switch flushes all wire state in the same cycle.
  always_comb begin
    flush  = ~wsi_en_i | (mode_pulse_i ^ mode_q);
    lvl_d  = '0;
    cnt_d  = '0;
    prev_d = '0;
    if (flush) begin
      lvl_d  = '0;
      prev_d = '0;
    end else if (mode_pulse_i) begin
      prev_d = act;
      for (int v = 0; v < int'(N_INT_VEC); v++) begin
        if (rise_hit[v]) begin
          cnt_d[v] = CNT_MAX;
        end else if (cnt_q[v] != '0) begin
          cnt_d[v] = cnt_q[v] - CNT_ONE;
        end else begin
          cnt_d[v] = '0;
        end
      end
    end else begin
      lvl_d = lvl_hit;
    end
    for (int v = 0; v < int'(N_INT_VEC); v++) begin
      wires_d[v] = mode_pulse_i ? (cnt_d[v] != '0) : lvl_d[v];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ip_q    <= '0;
      prev_q  <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      wires_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      prev_q  <= prev_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      wires_q <= wires_d;
      mode_q  <= mode_pulse_i;
    end
  end

  assign ip_o        = ip_q;
  assign wsi_wires_o = wires_q;

endmodule

// File: tb/tb_rv_iommu_wsi_gen.sv
// Directed and reference-model checks for rv_iommu_wsi_gen (N_INT_VEC=12 so
// ivec values 12..15 exercise the out-of-range path).
module tb_rv_iommu_wsi_gen;
  localparam int NS = 4;
  localparam int NV = 12;
  localparam int PC = 4;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [NS*VW-1:0] ivec;
  logic [NS-1:0] ie;
  logic [NS-1:0] set;
  logic [NS-1:0] clr;
  logic [NS-1:0] ip;
  logic [NV-1:0] wires;

  int n_total = 0;
  int n_bad   = 0;

  int m_ip[NS];
  int m_prev[NS];
  int m_cnt[NV];
  logic [NV-1:0] m_wires;
  logic m_mode;

  rv_iommu_wsi_gen #(.N_SRC(NS), .N_INT_VEC(NV), .PULSE_CYCLES(PC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wsi_en_i(en), .mode_pulse_i(mode),
    .ivec_i(ivec), .ie_i(ie), .ip_set_i(set), .ip_clr_i(clr),
    .ip_o(ip), .wsi_wires_o(wires)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model evaluated on the inputs seen at a rising edge.
  task automatic model_update();
    int act[NS];
    int vec;
    logic flush;
    logic hl, hr;
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin m_ip[s] = 0; m_prev[s] = 0; end
      for (int v = 0; v < NV; v++) m_cnt[v] = 0;
      m_wires = '0;
      m_mode  = 1'b0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        vec = int'(ivec[s*VW +: VW]);
        act[s] = (m_ip[s] != 0 && ie[s] && vec < NV) ? 1 : 0;
      end
      flush = !en || (mode != m_mode);
      for (int v = 0; v < NV; v++) begin
        hl = 1'b0; hr = 1'b0;
        for (int s = 0; s < NS; s++) begin
          if (act[s] != 0 && int'(ivec[s*VW +: VW]) == v) begin
            hl = 1'b1;
            if (m_prev[s] == 0) hr = 1'b1;
          end
        end
        if (flush) begin
          m_cnt[v] = 0; m_wires[v] = 1'b0;
        end else if (mode) begin
          m_cnt[v] = hr ? PC : (m_cnt[v] > 0 ? m_cnt[v] - 1 : 0);
          m_wires[v] = (m_cnt[v] > 0);
        end else begin
          m_cnt[v] = 0; m_wires[v] = hl;
        end
      end
      for (int s = 0; s < NS; s++) begin
        m_prev[s] = (!flush && mode) ? act[s] : 0;
        m_ip[s] = set[s] ? 1 : (clr[s] ? 0 : m_ip[s]);
      end
      m_mode = mode;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_vec(input int s, input int v);
    logic [VW-1:0] tmp;
    tmp = VW'(v);
    ivec[s*VW +: VW] = tmp;
  endtask

  function automatic logic [NS-1:0] model_ip();
    logic [NS-1:0] r;
    for (int s = 0; s < NS; s++) r[s] = (m_ip[s] != 0);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; ivec = '0; ie = '0; set = '0; clr = '0;
    step(); step();
    check_eq("reset_ip", 32'(ip), 32'h0);
    check_eq("reset_wires", 32'(wires), 32'h0);

    // 1: level mode latency and clear
    rst_n = 1'b1; en = 1'b1; ie = 4'b0001; set_vec(0, 3);
    step();
    set[0] = 1'b1; step(); set = '0;
    check_eq("lvl_ip_t1", 32'(ip), 32'h1);
    check_eq("lvl_wire_t1", 32'(wires), 32'h0);
    step();
    check_eq("lvl_wire_t2", 32'(wires), 32'h008);
    step(); step();
    clr[0] = 1'b1; step(); clr = '0;
    check_eq("lvl_clr_ip", 32'(ip), 32'h0);
    check_eq("lvl_clr_t1", 32'(wires), 32'h008);
    step();
    check_eq("lvl_clr_t2", 32'(wires), 32'h0);

    // 2: set beats clear; ie gating
    set_vec(1, 5); set[1] = 1'b1; clr[1] = 1'b1; step(); set = '0; clr = '0;
    check_eq("set_wins", 32'(ip), 32'h2);
    step();
    check_eq("ie_off_wire", 32'(wires), 32'h0);
    ie = 4'b0011; step();
    check_eq("ie_on_wire", 32'(wires), 32'h020);
    en = 1'b0; step();
    check_eq("en_off_wire", 32'(wires), 32'h0);
    check_eq("en_off_ip", 32'(ip), 32'h2);
    clr[1] = 1'b1; en = 1'b1; step(); clr = '0;

    // 3: single pulse, steady pending, re-pulse after clear
    mode = 1'b1; ie = 4'b0100; set_vec(2, 0); step(); step();
    set[2] = 1'b1; step(); set = '0;
    check_eq("pls_t1", 32'(wires), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq($sformatf("pls1_%0d", k), 32'(wires), (k < 4) ? 32'h1 : 32'h0);
    end
    clr[2] = 1'b1; step(); clr = '0; step(); step();
    set[2] = 1'b1; step(); set = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("pls2_%0d", k), 32'(wires), (k < 4) ? 32'h1 : 32'h0);
    end

    // 4: shared vector reload extends the pulse without a gap
    ie = 4'b0011; set_vec(0, 7); set_vec(1, 7);
    set[0] = 1'b1; step(); set = '0;
    step();
    check_eq("rl_c2", 32'(wires), 32'h080);
    set[1] = 1'b1; step(); set = '0;
    for (int c = 3; c <= 8; c++) begin
      check_eq($sformatf("rl_c%0d", c), 32'(wires), (c <= 7) ? 32'h080 : 32'h0);
      step();
    end

    // 5: out-of-range ivec; disable mid-pulse then re-enable
    clr = 4'hF; step(); clr = '0; step();
    ie = 4'b1000; set_vec(3, 15);
    set[3] = 1'b1; step(); set = '0;
    check_eq("oor_ip", 32'(ip), 32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("oor_w%0d", k), 32'(wires), 32'h0);
    end
    ie = 4'b1001;
    set[0] = 1'b1; step(); set = '0;
    step(); check_eq("en_p0", 32'(wires), 32'h080);
    step(); check_eq("en_p1", 32'(wires), 32'h080);
    step(); check_eq("en_p2", 32'(wires), 32'h080);
    en = 1'b0; step();
    check_eq("en_cut_w", 32'(wires), 32'h0);
    check_eq("en_cut_ip", 32'(ip), 32'h9);
    en = 1'b1; step();
    check_eq("reen_p0", 32'(wires), 32'h080);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq($sformatf("reen_%0d", k), 32'(wires), (k < 3) ? 32'h080 : 32'h0);
    end

    // 6: reset mid-pulse and mid-level
    clr[0] = 1'b1; step(); clr = '0; step();
    set[0] = 1'b1; step(); set = '0; step();
    check_eq("rst_pls_pre", 32'(wires), 32'h080);
    rst_n = 1'b0; step();
    check_eq("rst_pls_w", 32'(wires), 32'h0);
    check_eq("rst_pls_ip", 32'(ip), 32'h0);
    rst_n = 1'b1; mode = 1'b0; ie = 4'b0001;
    set[0] = 1'b1; step(); set = '0; step();
    check_eq("rst_lvl_pre", 32'(wires), 32'h080);
    rst_n = 1'b0; step();
    check_eq("rst_lvl_w", 32'(wires), 32'h0);
    check_eq("rst_lvl_ip", 32'(ip), 32'h0);
    rst_n = 1'b1; step();

    // Random stream against the reference model
    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < NS; s++) begin
        set[s] = ($urandom_range(0, 3) == 0);
        clr[s] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 7) == 0) ie = NS'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ivec = (NS*VW)'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      en = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
      check_eq($sformatf("rnd_ip_%0d", i), 32'(ip), 32'(model_ip()));
      check_eq($sformatf("rnd_w_%0d", i), 32'(wires), 32'(m_wires));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
